// File: rtl/sha256_target_checker.sv
// sha256_target_checker
//   Reads the 8-word SHA-256 digest back from the shared single-port memory.
//   Counts the leading zero bits across the 256-bit digest (word 0 = H0 = MSBs)
//   and compares the count with a difficulty target. Optionally writes one
//   result word {meets_target, 22'b0, lz_count} to memory. Reports pass/fail
//   to the miner controller.
//
// Parameters
//   NUM_WORDS    : digest words read (word 0 is the most significant)
//   WRITE_RESULT : 1 = write result word to result_addr, 0 = skip WRITE state
//
// Optional feature macro: SHA256_TARGET_CHECKER_BEST_TRACK_EN
//   Adds best_lz / best_nonce, which track the highest leading-zero count seen
//   since reset and the nonce that produced it (ties keep the earlier nonce).
//
// Ports
//   clk, reset_n (async, active-low)
//   start, hash_addr, result_addr, target_zeros, nonce_tag : run request
//   done, meets_target, lz_count                           : run result
//   mem_clk, mem_we, mem_addr, mem_write_data, mem_read_data: memory port
//     (read data is valid on the 2nd rising edge after mem_addr is registered)
module sha256_target_checker #(
  parameter int NUM_WORDS    = 8,
  parameter bit WRITE_RESULT = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [15:0] hash_addr,
  input  logic [15:0] result_addr,
  input  logic [8:0]  target_zeros,
  input  logic [31:0] nonce_tag,
  output logic        done,
  output logic        meets_target,
  output logic [8:0]  lz_count,
`ifdef SHA256_TARGET_CHECKER_BEST_TRACK_EN
  output logic [8:0]  best_lz,
  output logic [31:0] best_nonce,
`endif
  output logic        mem_clk,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WAIT  = 3'd1;
  localparam logic [2:0] S_READ  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  logic [2:0]       state;
  logic [IDX_W-1:0] idx;
  logic             zero_run;
  logic [15:0]      hash_q;
  logic [15:0]      result_q;
  logic [8:0]       target_q;
  logic [5:0]       word_lz;
  logic [8:0]       lz_next;
  logic             last_word;

  // Leading-zero count of one word; an all-zero word yields 32.
  function automatic logic [5:0] clz32(input logic [31:0] w);
    logic [5:0] n;
    logic       found;
    n     = 6'd0;
    found = 1'b0;
    for (int b = 31; b >= 0; b--) begin
      if (!found) begin
        if (w[b]) found = 1'b1;
        else      n = n + 6'd1;
      end
    end
    return n;
  endfunction

  assign mem_clk   = clk;
  assign last_word = (idx == LAST_IDX);

  // Once a non-zero word has been seen the run of zeros is over, so later
  // words contribute nothing even if they are zero.
  always_comb begin
    word_lz = clz32(mem_read_data);
    lz_next = lz_count;
    if (zero_run) lz_next = lz_count + 9'(word_lz);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= S_IDLE;
      idx            <= '0;
      zero_run       <= 1'b0;
      hash_q         <= 16'd0;
      result_q       <= 16'd0;
      target_q       <= 9'd0;
      done           <= 1'b0;
      meets_target   <= 1'b0;
      lz_count       <= 9'd0;
      mem_we         <= 1'b0;
      mem_addr       <= 16'd0;
      mem_write_data <= 32'd0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          mem_we <= 1'b0;
          if (start) begin
            hash_q   <= hash_addr;
            result_q <= result_addr;
            target_q <= target_zeros;
            lz_count <= 9'd0;
            done     <= 1'b0;
            zero_run <= 1'b1;
            idx      <= '0;
            mem_addr <= hash_addr;
            state    <= S_WAIT;
          end else if (state == S_DONE) begin
            done <= 1'b1;
          end
        end
        S_WAIT: begin
          mem_addr <= hash_q + 16'd1;
          state    <= S_READ;
        end
        S_READ: begin
          lz_count <= lz_next;
          if (mem_read_data != 32'd0) zero_run <= 1'b0;
          // Keep the address stream running; reads past the digest are harmless.
          mem_addr <= hash_q + 16'(idx) + 16'd2;
          idx      <= idx + 1'b1;
          if (last_word) begin
            meets_target <= (lz_next >= target_q);
            state        <= WRITE_RESULT ? S_WRITE : S_DONE;
          end
        end
        S_WRITE: begin
          mem_we         <= 1'b1;
          mem_addr       <= result_q;
          mem_write_data <= {meets_target, 22'b0, lz_count};
          state          <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef SHA256_TARGET_CHECKER_BEST_TRACK_EN
  logic [31:0] nonce_q;
  logic        enter_done;
  logic [8:0]  final_lz;

  // The final count is still in flight when DONE is entered straight from READ.
  assign enter_done = (state == S_WRITE) ||
                      ((state == S_READ) && last_word && !WRITE_RESULT);
  assign final_lz   = (state == S_READ) ? lz_next : lz_count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      nonce_q    <= 32'd0;
      best_lz    <= 9'd0;
      best_nonce <= 32'd0;
    end else begin
      if ((state == S_IDLE || state == S_DONE) && start) nonce_q <= nonce_tag;
      if (enter_done && (final_lz > best_lz)) begin
        best_lz    <= final_lz;
        best_nonce <= nonce_q;
      end
    end
  end
`else
  // The nonce only matters when best tracking is compiled in.
  logic unused_nonce;
  assign unused_nonce = ^nonce_tag;
`endif

endmodule

// File: tb/tb_sha256_target_checker.sv
// Directed testbench for sha256_target_checker. Two instances share stimulus
// and a 64K-word memory: dut_a writes its result (WRITE_RESULT=1), dut_b does
// not (WRITE_RESULT=0).
module tb_sha256_target_checker;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [15:0] hash_addr;
  logic [15:0] result_addr;
  logic [8:0]  target_zeros;
  logic [31:0] nonce_tag;

  logic        a_done, a_meets, a_mem_clk, a_mem_we;
  logic [8:0]  a_lz;
  logic [15:0] a_mem_addr;
  logic [31:0] a_wdata, rd_a;
  logic        b_done, b_meets, b_mem_clk, b_mem_we;
  logic [8:0]  b_lz;
  logic [15:0] b_mem_addr;
  logic [31:0] b_wdata, rd_b;
`ifdef SHA256_TARGET_CHECKER_BEST_TRACK_EN
  logic [8:0]  a_best_lz, b_best_lz;
  logic [31:0] a_best_nonce, b_best_nonce;
`endif

  logic [31:0] mem [0:65535];
  int          wr_cnt_a = 0;
  int          wr_cnt_b = 0;
  logic [15:0] wr_addr_a = 16'd0;
  logic [31:0] wr_data_a = 32'd0;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  sha256_target_checker #(.NUM_WORDS(8), .WRITE_RESULT(1'b1)) dut_a (
    .clk(clk), .reset_n(reset_n), .start(start), .hash_addr(hash_addr),
    .result_addr(result_addr), .target_zeros(target_zeros), .nonce_tag(nonce_tag),
    .done(a_done), .meets_target(a_meets), .lz_count(a_lz),
`ifdef SHA256_TARGET_CHECKER_BEST_TRACK_EN
    .best_lz(a_best_lz), .best_nonce(a_best_nonce),
`endif
    .mem_clk(a_mem_clk), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
    .mem_write_data(a_wdata), .mem_read_data(rd_a)
  );

  sha256_target_checker #(.NUM_WORDS(8), .WRITE_RESULT(1'b0)) dut_b (
    .clk(clk), .reset_n(reset_n), .start(start), .hash_addr(hash_addr),
    .result_addr(result_addr), .target_zeros(target_zeros), .nonce_tag(nonce_tag),
    .done(b_done), .meets_target(b_meets), .lz_count(b_lz),
`ifdef SHA256_TARGET_CHECKER_BEST_TRACK_EN
    .best_lz(b_best_lz), .best_nonce(b_best_nonce),
`endif
    .mem_clk(b_mem_clk), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
    .mem_write_data(b_wdata), .mem_read_data(rd_b)
  );

  // One registered read stage: data for an address registered at edge N is
  // sampled by the DUT at edge N+2.
  always @(posedge clk) begin
    rd_a <= mem[a_mem_addr];
    rd_b <= mem[b_mem_addr];
    if (a_mem_we) begin
      wr_cnt_a  <= wr_cnt_a + 1;
      wr_addr_a <= a_mem_addr;
      wr_data_a <= a_wdata;
    end
    if (b_mem_we) wr_cnt_b <= wr_cnt_b + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_digest(input logic [15:0] base, input logic [255:0] dig);
    for (int i = 0; i < 8; i++) mem[base + 16'(i)] = dig[255 - 32*i -: 32];
  endtask

  // Full run: start at edge 0, optional start pulse at edge pulse_at (ignored
  // by the DUT), then timing, result and write checks.
  task automatic run(input string tag, input logic [15:0] ha, input logic [15:0] ra,
                     input logic [8:0] tz, input logic [31:0] nt, input int pulse_at,
                     input logic [8:0] exp_lz, input logic exp_meets);
    int wa0, wb0;
    wa0 = wr_cnt_a;
    wb0 = wr_cnt_b;
    @(negedge clk);
    hash_addr = ha; result_addr = ra; target_zeros = tz; nonce_tag = nt; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    chk({tag, "_done_drop"}, 64'(a_done), 64'd0);
    for (int e = 1; e <= 10; e++) begin
      if (e == pulse_at) start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
    end
    chk({tag, "_a_done_e10"}, 64'(a_done), 64'd0);
    chk({tag, "_b_done_e10"}, 64'(b_done), 64'd1);
    @(posedge clk); #1;
    chk({tag, "_a_done_e11"}, 64'(a_done), 64'd1);
    chk({tag, "_a_lz"}, 64'(a_lz), 64'(exp_lz));
    chk({tag, "_a_meets"}, 64'(a_meets), 64'(exp_meets));
    chk({tag, "_b_lz"}, 64'(b_lz), 64'(exp_lz));
    chk({tag, "_b_meets"}, 64'(b_meets), 64'(exp_meets));
    chk({tag, "_a_writes"}, 64'(wr_cnt_a - wa0), 64'd1);
    chk({tag, "_a_wr_addr"}, 64'(wr_addr_a), 64'(ra));
    chk({tag, "_a_wr_data"}, 64'(wr_data_a), 64'({exp_meets, 22'b0, exp_lz}));
    chk({tag, "_a_we_low"}, 64'(a_mem_we), 64'd0);
    chk({tag, "_b_writes"}, 64'(wr_cnt_b - wb0), 64'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_done"}, 64'(a_done), 64'd0);
    chk({tag, "_we"}, 64'(a_mem_we), 64'd0);
    chk({tag, "_addr"}, 64'(a_mem_addr), 64'd0);
    chk({tag, "_wdata"}, 64'(a_wdata), 64'd0);
    chk({tag, "_meets"}, 64'(a_meets), 64'd0);
    chk({tag, "_lz"}, 64'(a_lz), 64'd0);
    chk({tag, "_b_lz"}, 64'(b_lz), 64'd0);
`ifdef SHA256_TARGET_CHECKER_BEST_TRACK_EN
    chk({tag, "_best_lz"}, 64'(a_best_lz), 64'd0);
    chk({tag, "_best_nonce"}, 64'(a_best_nonce), 64'd0);
`endif
  endtask

  initial begin
    int wa0;
    reset_n = 1'b0; start = 1'b0; hash_addr = 16'd0; result_addr = 16'd0;
    target_zeros = 9'd0; nonce_tag = 32'd0;
    repeat (3) @(posedge clk);
    #1 chk_reset_outputs("rst");
    chk("mem_clk", 64'(a_mem_clk), 64'(clk));
    @(negedge clk) reset_n = 1'b1;

    set_digest(16'h0100, 256'h0);
    run("all_zero", 16'h0100, 16'h0200, 9'd256, 32'd1, 0, 9'd256, 1'b1);

    set_digest(16'h0300, {32'h00000FFF, 32'hDEADBEEF, 32'h0, 32'h12345678,
                          32'hFFFFFFFF, 32'h0, 32'hCAFEF00D, 32'h1});
    run("fff_t20", 16'h0300, 16'h0400, 9'd20, 32'd2, 0, 9'd20, 1'b1);
    run("fff_t21_pulse", 16'h0300, 16'h0401, 9'd21, 32'd3, 5, 9'd20, 1'b0);

    set_digest(16'h0500, {32'h80000000, 224'h0});
    run("msb_t0", 16'h0500, 16'h0600, 9'd0, 32'd4, 0, 9'd0, 1'b1);

    set_digest(16'h0700, 256'h0);
    run("zero_t300", 16'h0700, 16'h0800, 9'd300, 32'd5, 0, 9'd256, 1'b0);

    set_digest(16'h0900, {32'h0, 32'h80000000, 192'h0});
    run("h1_msb_t33", 16'h0900, 16'h0A00, 9'd33, 32'd6, 0, 9'd32, 1'b0);

    // Digest straddles the top of the address space.
    set_digest(16'hFFFC, {32'h0, 32'h0, 32'h0, 32'h00010000,
                          32'h12345678, 32'h0, 32'h0, 32'h0});
    run("wrap_t111", 16'hFFFC, 16'h0B00, 9'd111, 32'd7, 0, 9'd111, 1'b1);

    // Reset during READ aborts the run with no result write.
    wa0 = wr_cnt_a;
    @(negedge clk);
    hash_addr = 16'h0100; result_addr = 16'h0C00; target_zeros = 9'd1; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #1 reset_n = 1'b0;
    #1 chk_reset_outputs("midrst");
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    chk("midrst_no_write", 64'(wr_cnt_a - wa0), 64'd0);
    chk("midrst_idle_done", 64'(a_done), 64'd0);

    set_digest(16'h1000, {32'h00080000, 32'h55555555, 192'h0});
    run("best1", 16'h1000, 16'h1100, 9'd10, 32'd5, 0, 9'd12, 1'b1);
`ifdef SHA256_TARGET_CHECKER_BEST_TRACK_EN
    chk("best1_lz", 64'(a_best_lz), 64'd12);
    chk("best1_nonce", 64'(a_best_nonce), 64'd5);
`endif
    run("best2", 16'h0300, 16'h1101, 9'd20, 32'd9, 0, 9'd20, 1'b1);
    run("best3", 16'h0300, 16'h1102, 9'd25, 32'd11, 0, 9'd20, 1'b0);
`ifdef SHA256_TARGET_CHECKER_BEST_TRACK_EN
    chk("best3_a_lz", 64'(a_best_lz), 64'd20);
    chk("best3_a_nonce", 64'(a_best_nonce), 64'd9);
    chk("best3_b_lz", 64'(b_best_lz), 64'd20);
    chk("best3_b_nonce", 64'(b_best_nonce), 64'd9);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sha256_target_checker.md
Name: sha256_target_checker

Overview:
- Downstream consumer of the SHA-256 core. Runs after the core has written its 8-word digest to shared memory.
- Reads the digest back over the same single-port memory interface.
- Counts leading zero bits across the 256-bit digest and compares the count with a difficulty target.
- Writes one result word to memory and reports pass/fail to the miner controller.

Parameters:
- NUM_WORDS, 8, digest words read; word 0 is the most significant (H0).
- WRITE_RESULT, 1, when 1 the result word is written to result_addr; when 0 the WRITE state is skipped.

Ports:
- clk  in  1  system clock; mem_clk is driven from it.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  begin a check; sampled only in IDLE or DONE.
- hash_addr  in  16  memory address of digest word 0.
- result_addr  in  16  memory address of the result word.
- target_zeros  in  9  required leading-zero count (0..256).
- nonce_tag  in  32  nonce associated with this digest (used by the optional feature).
- done  out  1  level; high in DONE until the next accepted start.
- meets_target  out  1  valid while done is high.
- lz_count  out  9  leading-zero count, 0..256.
- mem_clk  out  1  equals clk.
- mem_we  out  1  memory write enable.
- mem_addr  out  16  memory address.
- mem_write_data  out  32  memory write data.
- mem_read_data  in  32  memory read data; valid on the 2nd rising edge after mem_addr is registered.

Behaviour:
- Reset: state IDLE. done, mem_we, mem_addr, mem_write_data, meets_target, lz_count and the internal word index all go to 0.
- States: IDLE, WAIT, READ, WRITE, DONE.
- IDLE/DONE with start=1 (edge 0):
  - latch hash_addr, result_addr, target_zeros, nonce_tag
  - clear lz_count and done; set the zero_run flag
  - mem_addr <= hash_addr; go to WAIT
- WAIT (edge 1): mem_addr <= hash_addr+1; go to READ.
- READ (edges 2..NUM_WORDS+1): sample word i from mem_read_data. mem_addr <= hash_addr+i+2; extra trailing reads are harmless.
  - If zero_run and word==0: lz_count += 32.
  - If zero_run and word!=0: lz_count += clz(word) and clear zero_run.
  - If zero_run is already clear, the word is ignored.
  - After the last word: meets_target <= (lz_count_final >= target_zeros), unsigned 9-bit compare. Go to WRITE, or to DONE when WRITE_RESULT=0.
- WRITE (1 cycle):
  - mem_we <= 1, mem_addr <= result_addr
  - mem_write_data <= {meets_target, 22'b0, lz_count}
  - go to DONE
- DONE:
  - mem_we <= 0, done <= 1; hold all outputs.
  - A new start restarts at edge 0 of the sequence and drops done.
- Latency: done is visible after edge 11 with WRITE_RESULT=1, after edge 10 with WRITE_RESULT=0.
- start is ignored in WAIT, READ and WRITE.
- mem_we is high for exactly one cycle per run.
- target_zeros=0 always passes. Values above 256 always fail.
- Asserting reset_n low mid-run aborts immediately: no write issues and all outputs return to reset values.
- Address arithmetic is 16-bit with wrap-around modulo 2^16.

Optional Feature:
- Macro: SHA256_TARGET_CHECKER_BEST_TRACK_EN.
- Defined:
  - adds outputs best_lz [8:0] and best_nonce [31:0], both reset to 0
  - on entry to DONE, if lz_count > best_lz (strictly greater): best_lz <= lz_count and best_nonce <= latched nonce_tag
  - ties keep the earlier nonce
  - values persist across runs and are cleared only by reset
- Undefined: the ports and registers do not exist and behaviour is otherwise identical.

Test Plan:
- Digest all 0x00000000, target 256 -> lz_count=256, meets_target=1, memory[result_addr]=0x8000_0100, done after edge 11.
- H0=0x00000FFF, rest arbitrary, target 20 -> lz_count=20, meets=1. Same digest with target 21 -> meets=0, result word 0x0000_0014.
- H0=0, H1=0x80000000, H2..H7=0 -> lz_count=32 (later zero words must not add). H0=0x80000000 -> lz_count=0.
- WRITE_RESULT=0 -> mem_we never asserts, done after edge 10; start pulsed during READ -> ignored, single write per run.
- reset_n low during READ -> outputs zero, no write to result_addr; fresh start afterwards completes normally.
- BEST_TRACK_EN: runs with lz 12 (nonce 5), 20 (nonce 9), 20 (nonce 11) -> best_lz=20, best_nonce=9.
